// File: rtl/hazard_unit_pkg.sv
// Shared LC-3b pipeline types used by the hazard controller.
// Forwarding select encodings, shadow-entry layout and hazard FSM states.
package lc3b_types;

   typedef logic [2:0] lc3b_reg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } lc3b_fwd_sel;

   typedef struct packed {
      logic    valid;
      lc3b_reg dest;
      logic    writes;
      logic    is_load;
      lc3b_reg src1;
      lc3b_reg src2;
      logic    src1_used;
      logic    src2_used;
   } lc3b_hazard_entry;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_MWAIT = 1'b1
   } lc3b_hazard_state;

   localparam lc3b_hazard_entry HZ_ENTRY_NONE = '0;

   function automatic logic hz_produces(input lc3b_hazard_entry e, input lc3b_reg r);
      return e.valid && e.writes && (e.dest == r);
   endfunction

   // A load sitting in MEM has no data yet, so it is skipped and WB is tried next.
   function automatic lc3b_fwd_sel hz_fwd_select(
      input lc3b_reg          src,
      input logic             used,
      input lc3b_hazard_entry mem,
      input lc3b_hazard_entry wb
   );
      lc3b_fwd_sel sel;
      sel = FWD_REG;
      if (used) begin
         if (hz_produces(mem, src) && !mem.is_load)
            sel = FWD_MEM;
         else if (hz_produces(wb, src))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_shadow_reg.sv
// One pipeline-stage shadow entry of the hazard controller.
// On load the entry takes d, or goes invalid when clear is also set.
module hazard_shadow_reg
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             clear,
   input  lc3b_hazard_entry d,
   output lc3b_hazard_entry q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q <= HZ_ENTRY_NONE;
      else if (load)
         q <= clear ? HZ_ENTRY_NONE : d;
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage LC-3b core: stage shadows, EX forwarding
// selects, memory-wait advance control, load-use bubbles and branch flushes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   HZ_RUN   | pipeline advancing; a missing response stalls and enters MWAIT
//   HZ_MWAIT | waiting for outstanding fetch and/or data responses
module hazard_unit
   import lc3b_types::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [2:0]       id_src1,
   input  logic [2:0]       id_src2,
   input  logic             id_src1_used,
   input  logic             id_src2_used,
   input  logic [2:0]       id_dest,
   input  logic             id_writes_reg,
   input  logic             id_is_load,
   input  logic             imem_resp,
   input  logic             dmem_req,
   input  logic             dmem_resp,
   input  logic             br_taken,
   output logic [1:0]       alu_input_one_mux_sel,
   output logic [1:0]       alu_input_two_mux_sel,
   output logic             advance,
   output logic             stall_if_id,
   output logic             bubble_ex,
   output logic             flush,
   output logic [CNT_W-1:0] stall_count
);

   lc3b_hazard_state state, state_nxt;
   logic             imem_seen, imem_seen_nxt;
   logic             dmem_seen, dmem_seen_nxt;
   logic             imem_ok, dmem_ok, mem_pending;

   lc3b_hazard_entry id_entry, ex_q, mem_q, wb_q;
   logic             load_use;
   logic             ex_clear;
   lc3b_fwd_sel      sel_one, sel_two;

   assign id_entry = '{
      valid:     id_valid,
      dest:      id_dest,
      writes:    id_writes_reg,
      is_load:   id_is_load,
      src1:      id_src1,
      src2:      id_src2,
      src1_used: id_src1_used,
      src2_used: id_src2_used
   };

   assign mem_pending = (dmem_req && !dmem_resp) || !imem_resp;
   // Responses are single-cycle pulses, so ones already seen are remembered.
   assign imem_ok     = imem_seen || imem_resp;
   assign dmem_ok     = dmem_seen || !dmem_req || dmem_resp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HZ_RUN;
         imem_seen <= 1'b0;
         dmem_seen <= 1'b0;
      end else begin
         state     <= state_nxt;
         imem_seen <= imem_seen_nxt;
         dmem_seen <= dmem_seen_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      imem_seen_nxt = 1'b0;
      dmem_seen_nxt = 1'b0;
      advance       = 1'b1;
      case (state)
         HZ_RUN: begin
            if (mem_pending) begin
               advance       = 1'b0;
               state_nxt     = HZ_MWAIT;
               imem_seen_nxt = imem_resp;
               dmem_seen_nxt = !dmem_req || dmem_resp;
            end
         end
         HZ_MWAIT: begin
            if (imem_ok && dmem_ok) begin
               state_nxt = HZ_RUN;
            end else begin
               advance       = 1'b0;
               imem_seen_nxt = imem_ok;
               dmem_seen_nxt = dmem_ok;
            end
         end
         default: begin
            state_nxt = HZ_RUN;
         end
      endcase
   end

   assign load_use = id_valid && ex_q.valid && ex_q.writes && ex_q.is_load &&
                     ((id_src1_used && (ex_q.dest == id_src1)) ||
                      (id_src2_used && (ex_q.dest == id_src2)));

   assign flush       = br_taken;
   assign bubble_ex   = load_use && !br_taken;
   assign stall_if_id = bubble_ex;
   assign ex_clear    = bubble_ex || flush || !id_valid;

   hazard_shadow_reg u_ex_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (advance),
      .clear   (ex_clear),
      .d       (id_entry),
      .q       (ex_q)
   );

   hazard_shadow_reg u_mem_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (advance),
      .clear   (flush),
      .d       (ex_q),
      .q       (mem_q)
   );

   hazard_shadow_reg u_wb_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (advance),
      .clear   (1'b0),
      .d       (mem_q),
      .q       (wb_q)
   );

   always_comb begin
      sel_one = FWD_REG;
      sel_two = FWD_REG;
      if (ex_q.valid) begin
         sel_one = hz_fwd_select(ex_q.src1, ex_q.src1_used, mem_q, wb_q);
         sel_two = hz_fwd_select(ex_q.src2, ex_q.src2_used, mem_q, wb_q);
      end
   end

   assign alu_input_one_mux_sel = sel_one;
   assign alu_input_two_mux_sel = sel_two;

   // Source fields only matter in EX; downstream copies ride along unread.
   logic unused_src;
   assign unused_src = ^{mem_q.src1, mem_q.src2, mem_q.src1_used, mem_q.src2_used,
                         wb_q.src1, wb_q.src2, wb_q.src1_used, wb_q.src2_used,
                         wb_q.is_load};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_count <= '0;
      else if ((!advance || bubble_ex) && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a stage-list reference model.
module tb_hazard_unit;
   import lc3b_types::*;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             id_valid = 1'b0;
   logic [2:0]       id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic             id_src1_used = 1'b0, id_src2_used = 1'b0;
   logic             id_writes_reg = 1'b0, id_is_load = 1'b0;
   logic             imem_resp = 1'b1, dmem_req = 1'b0, dmem_resp = 1'b0;
   logic             br_taken = 1'b0;
   logic [1:0]       alu_input_one_mux_sel, alu_input_two_mux_sel;
   logic             advance, stall_if_id, bubble_ex, flush;
   logic [CNT_W-1:0] stall_count;

   hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .id_valid              (id_valid),
      .id_src1               (id_src1),
      .id_src2               (id_src2),
      .id_src1_used          (id_src1_used),
      .id_src2_used          (id_src2_used),
      .id_dest               (id_dest),
      .id_writes_reg         (id_writes_reg),
      .id_is_load            (id_is_load),
      .imem_resp             (imem_resp),
      .dmem_req              (dmem_req),
      .dmem_resp             (dmem_resp),
      .br_taken              (br_taken),
      .alu_input_one_mux_sel (alu_input_one_mux_sel),
      .alu_input_two_mux_sel (alu_input_two_mux_sel),
      .advance               (advance),
      .stall_if_id           (stall_if_id),
      .bubble_ex             (bubble_ex),
      .flush                 (flush),
      .stall_count           (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit       v;
      bit [2:0] d;
      bit       w;
      bit       ld;
      bit [2:0] s1;
      bit       u1;
      bit [2:0] s2;
      bit       u2;
   } ins_t;

   typedef struct packed {
      bit [1:0]       sel1;
      bit [1:0]       sel2;
      bit             adv;
      bit             sif;
      bit             bub;
      bit             fl;
      bit [CNT_W-1:0] cnt;
   } exp_t;

   exp_t        sb[$];
   ins_t        m_ex, m_mem, m_wb;
   bit          m_wait, m_wi, m_wd;
   int unsigned m_cnt;
   int          checks = 0;
   int          passed = 0;
   bit          stim_done = 1'b0;
   bit          last_dq = 1'b0;

   localparam ins_t NOP = '0;

   function automatic ins_t mk(bit [2:0] d, bit w, bit ld,
                               bit [2:0] s1, bit u1, bit [2:0] s2, bit u2);
      ins_t i;
      i.v = 1'b1; i.d = d; i.w = w; i.ld = ld;
      i.s1 = s1; i.u1 = u1; i.s2 = s2; i.u2 = u2;
      return i;
   endfunction

   function automatic bit writes_reg(ins_t p, bit [2:0] r);
      return p.v && p.w && (p.d == r);
   endfunction

   // Nearest older producer wins; a load still in MEM cannot supply data.
   function automatic bit [1:0] ref_fwd(bit [2:0] r, bit used);
      if (!m_ex.v || !used) return 2'b00;
      if (writes_reg(m_mem, r) && !m_mem.ld) return 2'b01;
      if (writes_reg(m_wb, r)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic step(ins_t id, bit br, bit ir, bit dq, bit dr, bit rst);
      exp_t e;
      bit oi, od, adv, lu, bub;
      @(posedge clk);
      #1;
      reset_n       = !rst;
      id_valid      = id.v;
      id_dest       = id.d;
      id_writes_reg = id.w;
      id_is_load    = id.ld;
      id_src1       = id.s1;
      id_src1_used  = id.u1;
      id_src2       = id.s2;
      id_src2_used  = id.u2;
      br_taken      = br;
      imem_resp     = ir;
      dmem_req      = dq;
      dmem_resp     = dr;
      last_dq       = dq;
      if (rst) begin
         m_ex = NOP; m_mem = NOP; m_wb = NOP;
         m_wait = 1'b0; m_wi = 1'b0; m_wd = 1'b0; m_cnt = 0;
      end
      // Outstanding responses: a fresh request set when running, else what is still owed.
      if (!m_wait) begin
         oi = !ir;
         od = dq && !dr;
      end else begin
         oi = m_wi && !ir;
         od = m_wd && dq && !dr;
      end
      adv = !(oi || od);
      lu  = id.v && m_ex.v && m_ex.w && m_ex.ld &&
            ((id.u1 && id.s1 == m_ex.d) || (id.u2 && id.s2 == m_ex.d));
      bub = lu && !br;
      e.sel1 = ref_fwd(m_ex.s1, m_ex.u1);
      e.sel2 = ref_fwd(m_ex.s2, m_ex.u2);
      e.adv  = adv;
      e.sif  = bub;
      e.bub  = bub;
      e.fl   = br;
      e.cnt  = m_cnt[CNT_W-1:0];
      sb.push_back(e);
      if (!rst) begin
         if ((!adv || bub) && m_cnt < (2**CNT_W - 1)) m_cnt++;
         if (adv) begin
            m_wb  = m_mem;
            m_mem = br ? NOP : m_ex;
            m_ex  = (bub || br || !id.v) ? NOP : id;
         end
         m_wait = !adv;
         m_wi   = oi;
         m_wd   = od;
      end
   endtask

   task automatic run(ins_t id);
      step(id, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   initial begin
      exp_t e;
      int   idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            idle = 0;
            chk("sel1",        {30'd0, alu_input_one_mux_sel}, {30'd0, e.sel1});
            chk("sel2",        {30'd0, alu_input_two_mux_sel}, {30'd0, e.sel2});
            chk("advance",     {31'd0, advance},               {31'd0, e.adv});
            chk("stall_if_id", {31'd0, stall_if_id},           {31'd0, e.sif});
            chk("bubble_ex",   {31'd0, bubble_ex},             {31'd0, e.bub});
            chk("flush",       {31'd0, flush},                 {31'd0, e.fl});
            chk("stall_count", {16'd0, stall_count},           {16'd0, e.cnt});
         end else if (stim_done) begin
            break;
         end else begin
            idle++;
            if (idle > 200) begin
               checks++;
               $display("FAIL timeout: no stimulus for %0d cycles, required progress", idle);
               break;
            end
         end
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      ins_t id;
      bit   dq;
      m_ex = NOP; m_mem = NOP; m_wb = NOP;
      m_wait = 1'b0; m_wi = 1'b0; m_wd = 1'b0; m_cnt = 0;

      step(NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run(NOP);

      // ADD R1,R2,R3 ; ADD R4,R1,R1 -> both operands from MEM
      run(mk(3'd1, 1, 0, 3'd2, 1, 3'd3, 1));
      run(mk(3'd4, 1, 0, 3'd1, 1, 3'd1, 1));
      run(NOP); run(NOP); run(NOP);

      // ADD R1 ; NOP ; ADD R4,R1,#5 -> sel1 from WB, immediate operand
      run(mk(3'd1, 1, 0, 3'd2, 1, 3'd3, 1));
      run(NOP);
      run(mk(3'd4, 1, 0, 3'd1, 1, 3'd0, 0));
      run(NOP); run(NOP); run(NOP);

      // ADD R1 twice ; ADD R5,R1,R0 -> MEM wins over WB
      run(mk(3'd1, 1, 0, 3'd2, 1, 3'd3, 1));
      run(mk(3'd1, 1, 0, 3'd4, 1, 3'd5, 1));
      run(mk(3'd5, 1, 0, 3'd1, 1, 3'd0, 1));
      run(NOP); run(NOP); run(NOP);

      // LDR R1 ; ADD R3,R1,R0 held in ID across the bubble
      run(mk(3'd1, 1, 1, 3'd2, 1, 3'd0, 0));
      run(mk(3'd3, 1, 0, 3'd1, 1, 3'd0, 1));
      run(mk(3'd3, 1, 0, 3'd1, 1, 3'd0, 1));
      run(NOP); run(NOP); run(NOP);

      // data access answered on the third cycle, then reset in the middle of a repeat
      step(NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run(NOP); run(NOP);
      step(NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      run(NOP); run(NOP);

      // branch taken together with a load-use hit
      run(mk(3'd1, 1, 1, 3'd2, 1, 3'd0, 0));
      step(mk(3'd3, 1, 0, 3'd1, 1, 3'd0, 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run(mk(3'd6, 1, 0, 3'd1, 1, 3'd3, 1));
      run(NOP); run(NOP);

      for (int n = 0; n < 600; n++) begin
         id.v  = ($urandom_range(0, 4) != 0);
         id.d  = 3'($urandom_range(0, 3));
         id.w  = ($urandom_range(0, 4) != 0);
         id.ld = ($urandom_range(0, 2) == 0);
         id.s1 = 3'($urandom_range(0, 3));
         id.u1 = ($urandom_range(0, 3) != 0);
         id.s2 = 3'($urandom_range(0, 3));
         id.u2 = ($urandom_range(0, 1) != 0);
         dq = m_wait ? last_dq : ($urandom_range(0, 2) == 0);
         step(id, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
              dq, ($urandom_range(0, 1) != 0), ($urandom_range(0, 149) == 0));
      end

      run(NOP);
      stim_done = 1'b1;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage LC-3b core. It keeps a registered shadow of the register-destination information for the EX, MEM and WB stages, and drives the EX-stage ALU forwarding selects from that shadow. It also generates the global pipeline advance enable, load-use bubbles and branch flushes. It sits beside the stage registers and steers the EX datapath's `alu_input_one_mux_sel` / `alu_input_two_mux_sel`.

## Interface
- `CNT_W`, 16, width of the saturating stall-cycle counter.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`, `id_src2`  in  3 each  source register numbers of the ID instruction.
- `id_src1_used`, `id_src2_used`  in  1 each  operand is read from the regfile. `src2_used`=0 when alumux selects an immediate.
- `id_dest`  in  3  destination register.
- `id_writes_reg`  in  1  ID instruction loads the regfile.
- `id_is_load`  in  1  LDR/LDB/LDI.
- `imem_resp`  in  1  instruction fetch complete this cycle.
- `dmem_req`  in  1  MEM stage instruction accesses data memory.
- `dmem_resp`  in  1  data access complete this cycle.
- `br_taken`  in  1  MEM-stage branch/jump resolved taken.
- `alu_input_one_mux_sel`, `alu_input_two_mux_sel`  out  2 each  00=regfile/alumux, 01=mem_input, 10=wb_input.
- `advance`  out  1  load enable for all stage registers and PC.
- `stall_if_id`  out  1  hold PC and IF/ID while the rest advance.
- `bubble_ex`  out  1  load a NOP into ID/EX.
- `flush`  out  1  squash IF/ID, ID/EX and EX/MEM contents on this advance.
- `stall_count`  out  CNT_W  saturating count of cycles with `advance`=0 or `bubble_ex`=1.

## Operation
- Shadow entries EX, MEM and WB each hold {valid, dest, writes, is_load, src1, src2, src1_used, src2_used}. Only EX uses the src fields.
- Forwarding is evaluated per operand *n* for the EX entry. If `srcN_used` and the MEM entry is valid, writes, is not a load, and has dest==srcN, then sel=01. Otherwise, if the WB entry is valid, writes, and has dest==srcN, then sel=10. Otherwise sel=00. MEM has priority over WB. An invalid EX entry gives 00.
- A load in MEM never forwards; load-use detection guarantees it is never needed.
- Load-use is detected when `id_valid`, the EX entry is valid, writes and is a load, and its dest matches a used ID source. Then `bubble_ex`=1 and `stall_if_id`=1 for exactly one advancing cycle.
- Flush: `br_taken` gives `flush`=1. On the advancing edge, WB←MEM and MEM←invalid; EX←invalid is loaded in place of ID.
- Priority: memory wait > flush > load-use. Under flush, `bubble_ex`=`stall_if_id`=0.
- FSM has two states:
  - RUN. If (`dmem_req` & !`dmem_resp`) or !`imem_resp`, go to MWAIT with `advance`=0.
  - MWAIT. Hold all shadows. Return to RUN in the cycle both pending responses are seen; `advance`=1 in that cycle.
- Shadow update occurs only when `advance`=1:
  - WB←MEM.
  - MEM←EX, or invalid under flush.
  - EX←ID, or invalid if bubble, flush or !`id_valid`.
- When `advance`=0, all shadows hold, and `flush`/`bubble_ex` remain asserted while their conditions persist.
- `stall_count` increments by 1 per qualifying cycle and saturates at all-ones.

## Timing
- All outputs except `stall_count` are combinational from the registered shadows/FSM plus current inputs, with zero latency. `stall_count` is registered.
- Reset (async assert, sync-released use) sets:
  - all shadows invalid, FSM=RUN, `stall_count`=0;
  - sels=00, `bubble_ex`=`stall_if_id`=`flush`=0.
  - `advance` then follows the memory inputs.
- Reset asserted mid-MWAIT returns to RUN with no pending state retained.
- A load-use bubble costs exactly 1 cycle. A memory wait of k cycles costs k cycles with no shadow change.

## Structure
- Add to `lc3b_types`:
  - enum `lc3b_fwd_sel` {FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10};
  - packed struct `lc3b_hazard_entry`;
  - enum `lc3b_hazard_state` {HZ_RUN, HZ_MWAIT}.
- One sub-module: `hazard_shadow_reg`, a single entry register with async reset, load enable and clear, instanced three times.

## Test plan
- ADD R1,R2,R3 followed by ADD R4,R1,R1 → when the second instruction is in EX, sel1=sel2=01.
- ADD R1; NOP; ADD R4,R1,#5 → sel1=10, sel2=00 (immediate, `src2_used`=0).
- ADD R1 twice, then ADD R5,R1,R0 → the MEM match wins: sel1=01.
- LDR R1; ADD R3,R1,R0 → `bubble_ex`=`stall_if_id`=1 for one cycle, then sel1=10 with no further stall.
- `dmem_req`=1 with `dmem_resp` in the third cycle → `advance`=0 for 2 cycles, 1 on the third; `stall_count`=2. Then `reset_n` low during a repeat → FSM=RUN, count=0.
- `br_taken` together with a load-use hit → `flush`=1, `bubble_ex`=0; after the edge, EX and MEM shadows are invalid and sels=00.
